// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in parallel-out receiver.
// Imported by the shift register and the receiver top level.
package sipo_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Word shift register with selectable bit order and restart-load.
// nxt is the value the register takes if loaded or shifted this edge.
module sipo_shreg
  import sipo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             load,
  input  logic             din,
  output logic [WIDTH-1:0] nxt
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] loaded;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {sr[WIDTH-2:0], din};
      assign loaded  = {{(WIDTH-1){1'b0}}, din};
    end else begin : g_lsb
      assign shifted = {din, sr[WIDTH-1:1]};
      assign loaded  = {din, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  assign nxt = load ? loaded : shifted;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sr <= '0;
    end else if (load || en) begin
      sr <= nxt;
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver with sync framing, a held output
// word, valid/ack handshake and sticky framing/overrun flags.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ack,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state, nstate;
  logic [CW-1:0]   cnt, cnt_n;
  logic            load;
  logic            shift;
  logic            done;
  logic            ferr_set;
  logic [WIDTH-1:0] word;

  sipo_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk (clk),
    .res (res),
    .en  (shift),
    .load(load),
    .din (sin),
    .nxt (word)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    nstate   = state;
    cnt_n    = cnt;
    load     = 1'b0;
    shift    = 1'b0;
    done     = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (sin_valid && sync) begin
          load   = 1'b1;
          cnt_n  = CW'(1);
          nstate = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_valid) begin
          unique case (1'b1)
            sync: begin
              load     = 1'b1;
              ferr_set = 1'b1;
              cnt_n    = CW'(1);
            end
            (cnt == LAST): begin
              shift  = 1'b1;
              done   = 1'b1;
              cnt_n  = '0;
              nstate = IDLE;
            end
            default: begin
              shift = 1'b1;
              cnt_n = cnt + CW'(1);
            end
          endcase
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // A same-edge ack consumes the old word, so only an unacked
  // completion over a valid word is an overrun.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      q         <= '0;
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_set) frame_err <= 1'b1;
      if (done) begin
        q       <= word;
        q_valid <= 1'b1;
        if (q_valid && !q_ack) overrun <= 1'b1;
      end else if (q_valid && q_ack) begin
        q_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in parallel-out receiver. It reassembles words shifted out one bit per strobe by the team's parallel-in serial-out shifter and presents each completed word on a held parallel output with a valid/acknowledge handshake. The block sits at the receiving end of the serial link. It frames words with a `sync` marker on the first bit and flags both framing errors and overruns.

## Interface

Parameters:
- `WIDTH`, default 4: bits per word; legal values are 2 to 32.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in `q[WIDTH-1]`; 0 means it lands in `q[0]`.

Ports:
- `clk`, input, 1: single clock; all state is updated on its rising edge.
- `res`, input, 1: reset, asynchronous and active-high.
- `sin`, input, 1: serial data bit.
- `sin_valid`, input, 1: `sin` is sampled on this edge; no bit is taken while it is low.
- `sync`, input, 1: qualified by `sin_valid`; marks the current bit as bit 0 of a new word.
- `q`, output, WIDTH: last completed word, held until overwritten.
- `q_valid`, output, 1: `q` holds an unacknowledged word.
- `q_ack`, input, 1: consumer accepts `q`; only effective while `q_valid` is 1.
- `busy`, output, 1: a word is partially received (state SHIFT).
- `frame_err`, output, 1: sticky; a word was aborted by `sync`.
- `overrun`, output, 1: sticky; an unacknowledged word was overwritten.

## Operation

FSM states: IDLE and SHIFT. Internal registers are a WIDTH-bit shift register `sr` and a bit counter `cnt` of width clog2(WIDTH+1).

- **IDLE:**
  - A bit accepted with `sync`=1 is loaded as bit 0; then `cnt`=1 and the FSM moves to SHIFT.
  - Bits accepted with `sync`=0 are discarded silently.
- **SHIFT:**
  - Each accepted bit is shifted into `sr` and increments `cnt`.
  - Shift direction:
    - `MSB_FIRST`=1: shift left, new bit enters at LSB. After WIDTH bits the first bit sits at MSB.
    - `MSB_FIRST`=0: shift right, new bit enters at MSB.
  - Word completion: when the accepted bit makes `cnt`==WIDTH, the assembled word, including this bit, is loaded into `q`. Then `q_valid` is set to 1, `cnt` returns to 0 and the FSM returns to IDLE.
  - An accepted bit with `sync`=1 in SHIFT aborts the partial word:
    - `frame_err` is set to 1.
    - The bit restarts a new word as bit 0 and `cnt` becomes 1.
    - The FSM stays in SHIFT.
- **Handshake:**
  - If `q_ack`=1 and `q_valid`=1 at an edge with no completion, `q_valid` is cleared to 0.
  - `q_ack` while `q_valid`=0 is ignored.
- **Completion while `q_valid`=1:**
  - With `q_ack`=0: `q` is overwritten, `q_valid` stays 1 and `overrun` is set.
  - With `q_ack`=1 on the same edge: the old word counts as consumed, `q` takes the new word, `q_valid` stays 1 and no overrun is flagged.
- `WIDTH`=1 is not supported.
- `frame_err` and `overrun` clear only on `res`.

## Timing

- **Reset values:**
  - `q`=0, `q_valid`=0, `busy`=0, `frame_err`=0, `overrun`=0.
  - `sr`=0, `cnt`=0, state IDLE.
- Reset is asynchronous: outputs go to their reset values immediately, without waiting for an edge.
- **Reset mid-word:** the partial word is lost and no `q_valid` is produced. After `res` falls, the receiver waits in IDLE for a new `sync`.
- **Latency:** `q` and `q_valid` update on the same edge that samples the last bit. They are visible one cycle after the bit was presented.
- **Throughput:** back-to-back words are supported with `sin_valid` held high continuously. The first bit of the next word needs `sync`=1 on the cycle immediately after completion.
- **Gaps:** gaps in `sin_valid` stall shifting without losing state.
- `busy` is high exactly while the state is SHIFT.

## Structure

- **Package `sipo_pkg`:**
  - State enum {IDLE, SHIFT}.
  - Default `WIDTH` constant.
  - Counter-width function clog2.
- **Sub-module `sipo_shreg`:**
  - WIDTH-bit shift register with `MSB_FIRST` direction, shift enable and synchronous restart-load.
  - The top level holds the FSM, counter, output register and flags.

## Test plan

1. **Single word:** `WIDTH`=4, `MSB_FIRST`=1; bits 1,0,0,1 on consecutive cycles, `sync` on the first -> `q`=4'b1001 and `q_valid`=1 after the 4th edge; `q_ack` one cycle later -> `q_valid`=0.
2. **LSB-first order:** `MSB_FIRST`=0, same bits 1,0,0,1 -> `q`=4'b1001. Repeat with bits 1,0,1,0 under both settings -> `q`=4'b1010 for `MSB_FIRST`=1, `q`=4'b0101 for `MSB_FIRST`=0.
3. **Framing error:** send 1,1 then `sync` with bits 0,1,1,0 -> `frame_err`=1 and `q`=4'b0110. No `q_valid` is produced for the aborted word.
4. **Overrun and acknowledge timing:**
   - Two back-to-back words, 1001 then 1010, with no `q_ack` -> `q`=4'b1010, `q_valid`=1, `overrun`=1.
   - Repeat with `q_ack` asserted on the completion edge of the second word -> `overrun`=0.
5. **Stalls and stray bits:** `sin_valid` toggled every other cycle while sending 1001 -> same `q`. Bits sent without `sync` in IDLE -> `q` unchanged, `busy`=0.
6. **Reset mid-word:** `res` pulsed after 2 bits -> all outputs 0 immediately. A subsequent synced 1010 -> `q`=4'b1010 and `q_valid`=1.
